// File: rtl/eth_lp_pkg.sv
// Shared FSM state type, slot counts and pulse-bit mapping for the link-pulse generator.
package eth_lp_pkg;

  typedef enum logic [1:0] {WAIT, SLOT, GAP} LpState;

  localparam int FLP_SLOTS = 33;
  localparam int NLP_SLOTS = 1;

  // Even FLP slots (and the single NLP slot) are clock pulses; odd slot k carries code[(k-1)/2].
  function automatic logic pulseBit(input logic [5:0] slotIdx, input logic [15:0] code,
                                    input logic flp);
    if (!flp || !slotIdx[0]) return 1'b1;
    return code[4'(slotIdx >> 1)];
  endfunction

endpackage

// File: rtl/eth_lp_interval_timer.sv
// Free-running wrap counter with synchronous clear; o_tc marks the last count of each period.
module eth_lp_interval_timer #(
  parameter int PERIOD = 320000
) (
  input  logic clk20,
  input  logic reset_n,
  input  logic i_clear,
  output logic o_tc
);

  localparam int W = $clog2(PERIOD);

  logic [W-1:0] r_count;
  logic         w_last;

  assign w_last = (r_count == W'(PERIOD - 1));
  assign o_tc   = w_last;

  always_ff @(posedge clk20 or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (i_clear || w_last) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/eth_link_pulse_gen.sv
// 10BASE-T NLP/FLP link-pulse generator with registered TD outputs.
// Optional negative tail after each pulse is built when ETH_LP_TAIL_EN is defined.
module eth_link_pulse_gen
  import eth_lp_pkg::*;
#(
  parameter int NLP_PERIOD  = 320000,
  parameter int SLOT_PERIOD = 1250,
  parameter int PULSE_WIDTH = 2,
  parameter int TAIL_WIDTH  = 1
) (
  input  logic        clk20,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        tx_active,
  input  logic        mode_flp,
  input  logic [15:0] link_code_word,
  output logic        Ethernet_TDp,
  output logic        Ethernet_TDm,
  output logic        pulse_strobe,
  output logic        burst_done
);

  localparam int CW         = $clog2(SLOT_PERIOD);
  localparam int GAP_CYCLES = SLOT_PERIOD - PULSE_WIDTH;

  LpState        r_state, w_nextState;
  logic [CW-1:0] r_cnt, w_nextCnt;
  logic [5:0]    r_slotIdx, w_nextIdx, w_lastIdx;
  logic          r_flp;
  logic [15:0]   r_code;
  logic          r_tdp, r_strobe, r_done;
  logic          w_tdpNext, w_strobeNext, w_doneNext;
  logic          w_hold, w_tc, w_burstStart, w_curBit, w_nextBit;

  assign w_hold       = !enable || tx_active;
  assign w_burstStart = (r_state == WAIT) && w_tc && !w_hold;
  assign w_lastIdx    = r_flp ? 6'(FLP_SLOTS - 1) : 6'(NLP_SLOTS - 1);
  assign w_curBit     = pulseBit(r_slotIdx, r_code, r_flp);
  assign w_nextBit    = pulseBit(r_slotIdx + 6'd1, r_code, r_flp);

  eth_lp_interval_timer #(.PERIOD(NLP_PERIOD)) u_timer (
    .clk20   (clk20),
    .reset_n (reset_n),
    .i_clear (w_hold),
    .o_tc    (w_tc)
  );

`ifdef ETH_LP_TAIL_EN
  logic r_tdm, w_tdmNext;
  assign Ethernet_TDm = r_tdm;
`else
  assign Ethernet_TDm = 1'b0;
  if (TAIL_WIDTH < 0) begin : g_tailUnused
  end
`endif

  // Outputs are computed for the next cycle and registered alongside the state.
  always_comb begin
    w_nextState  = r_state;
    w_nextCnt    = r_cnt;
    w_nextIdx    = r_slotIdx;
    w_tdpNext    = 1'b0;
    w_strobeNext = 1'b0;
    w_doneNext   = 1'b0;
`ifdef ETH_LP_TAIL_EN
    w_tdmNext    = 1'b0;
`endif
    if (w_hold) begin
      w_nextState = WAIT;
      w_nextCnt   = '0;
      w_nextIdx   = '0;
    end else begin
      case (r_state)
        WAIT: begin
          if (w_burstStart) begin
            w_nextState  = SLOT;
            w_nextCnt    = '0;
            w_nextIdx    = '0;
            w_tdpNext    = 1'b1;
            w_strobeNext = 1'b1;
          end
        end
        SLOT: begin
          if (r_cnt == CW'(PULSE_WIDTH - 1)) begin
            w_nextState = GAP;
            w_nextCnt   = '0;
`ifdef ETH_LP_TAIL_EN
            w_tdmNext   = w_curBit && (TAIL_WIDTH > 0);
`endif
          end else begin
            w_nextCnt = r_cnt + 1'b1;
            w_tdpNext = w_curBit;
          end
        end
        GAP: begin
          if (r_cnt == CW'(GAP_CYCLES - 1)) begin
            w_nextCnt = '0;
            if (r_slotIdx == w_lastIdx) begin
              w_nextState = WAIT;
              w_nextIdx   = '0;
              w_doneNext  = 1'b1;
            end else begin
              w_nextState  = SLOT;
              w_nextIdx    = r_slotIdx + 6'd1;
              w_tdpNext    = w_nextBit;
              w_strobeNext = w_nextBit;
            end
          end else begin
            w_nextCnt = r_cnt + 1'b1;
`ifdef ETH_LP_TAIL_EN
            w_tdmNext = w_curBit && ((int'(r_cnt) + 1) < TAIL_WIDTH);
`endif
          end
        end
        default: w_nextState = WAIT;
      endcase
    end
  end

  always_ff @(posedge clk20 or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= WAIT;
      r_cnt     <= '0;
      r_slotIdx <= '0;
    end else begin
      r_state   <= w_nextState;
      r_cnt     <= w_nextCnt;
      r_slotIdx <= w_nextIdx;
    end
  end

  // Mode and code word are frozen for the whole burst.
  always_ff @(posedge clk20 or negedge reset_n) begin
    if (!reset_n) begin
      r_flp  <= 1'b0;
      r_code <= '0;
    end else if (w_burstStart) begin
      r_flp  <= mode_flp;
      r_code <= link_code_word;
    end
  end

  always_ff @(posedge clk20 or negedge reset_n) begin
    if (!reset_n) begin
      r_tdp    <= 1'b0;
      r_strobe <= 1'b0;
      r_done   <= 1'b0;
`ifdef ETH_LP_TAIL_EN
      r_tdm    <= 1'b0;
`endif
    end else begin
      r_tdp    <= w_tdpNext;
      r_strobe <= w_strobeNext;
      r_done   <= w_doneNext;
`ifdef ETH_LP_TAIL_EN
      r_tdm    <= w_tdmNext;
`endif
    end
  end

  assign Ethernet_TDp = r_tdp;
  assign pulse_strobe = r_strobe;
  assign burst_done   = r_done;

endmodule

// File: tb/tb_eth_link_pulse_gen.sv
// Directed bench for eth_link_pulse_gen; cycle N means the Nth clock after reset release.
module tb_eth_link_pulse_gen;

  logic        clk20;
  logic        reset_n;
  logic        enable;
  logic        tx_active;
  logic        mode_flp;
  logic [15:0] link_code_word;
  logic        Ethernet_TDp;
  logic        Ethernet_TDm;
  logic        pulse_strobe;
  logic        burst_done;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int strobeCount  = 0;
  int doneCount    = 0;
  int overlapCount = 0;
  int snap;

  eth_link_pulse_gen #(
    .NLP_PERIOD  (1000),
    .SLOT_PERIOD (10),
    .PULSE_WIDTH (2),
    .TAIL_WIDTH  (1)
  ) dut (
    .clk20          (clk20),
    .reset_n        (reset_n),
    .enable         (enable),
    .tx_active      (tx_active),
    .mode_flp       (mode_flp),
    .link_code_word (link_code_word),
    .Ethernet_TDp   (Ethernet_TDp),
    .Ethernet_TDm   (Ethernet_TDm),
    .pulse_strobe   (pulse_strobe),
    .burst_done     (burst_done)
  );

  initial clk20 = 1'b0;
  always #5 clk20 = ~clk20;

  // Event counters sampled at the active edge, so cycle N's value is counted before cycle N+1 is observed.
  always @(posedge clk20) begin
    if (pulse_strobe === 1'b1) strobeCount <= strobeCount + 1;
    if (burst_done === 1'b1) doneCount <= doneCount + 1;
    if (Ethernet_TDp === 1'b1 && Ethernet_TDm === 1'b1) overlapCount <= overlapCount + 1;
  end

  task automatic applyStimulus(input logic en, input logic tx, input logic flp,
                               input logic [15:0] code);
    enable         = en;
    tx_active      = tx;
    mode_flp       = flp;
    link_code_word = code;
  endtask

  task automatic advanceTo(input int target);
    while (cyc < target) begin
      @(negedge clk20);
      cyc++;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
    repeat (3) @(negedge clk20);
    checkOutput("reset_tdp", Ethernet_TDp, 1'b0);
    checkOutput("reset_tdm", Ethernet_TDm, 1'b0);
    checkOutput("reset_strobe", pulse_strobe, 1'b0);
    checkOutput("reset_done", burst_done, 1'b0);

    $display("[TB] NLP bursts");
    reset_n = 1'b1;
    cyc = 0;
    advanceTo(999);
    checkOutput("nlp_before_first", Ethernet_TDp, 1'b0);
    advanceTo(1000);
    checkOutput("nlp_first_tdp", Ethernet_TDp, 1'b1);
    checkOutput("nlp_first_strobe", pulse_strobe, 1'b1);
    snap = strobeCount;
    advanceTo(1001);
    checkOutput("nlp_tdp_cycle2", Ethernet_TDp, 1'b1);
    checkOutput("nlp_strobe_once", pulse_strobe, 1'b0);
`ifdef ETH_LP_TAIL_EN
    checkOutput("tail_not_during_pulse", Ethernet_TDm, 1'b0);
`endif
    advanceTo(1002);
    checkOutput("nlp_tdp_end", Ethernet_TDp, 1'b0);
`ifdef ETH_LP_TAIL_EN
    checkOutput("tail_after_pulse", Ethernet_TDm, 1'b1);
    advanceTo(1003);
    checkOutput("tail_width", Ethernet_TDm, 1'b0);
`endif
    advanceTo(1009);
    checkOutput("nlp_done_early", burst_done, 1'b0);
    advanceTo(1010);
    checkOutput("nlp_done", burst_done, 1'b1);
    advanceTo(1011);
    checkOutput("nlp_done_one_cycle", burst_done, 1'b0);
    advanceTo(2000);
    checkOutput("nlp_second_tdp", Ethernet_TDp, 1'b1);
    checkOutput("nlp_strobes_per_period", strobeCount - snap, 1);

    $display("[TB] FLP burst with code A5A5");
    applyStimulus(1'b1, 1'b0, 1'b1, 16'hA5A5);
    advanceTo(3000);
    checkOutput("flp_slot0", Ethernet_TDp, 1'b1);
    snap = strobeCount;
    advanceTo(3010);
    checkOutput("flp_slot1_d0", Ethernet_TDp, 1'b1);
    advanceTo(3030);
    checkOutput("flp_slot3_d1", Ethernet_TDp, 1'b0);
    advanceTo(3329);
    checkOutput("flp_done_early", burst_done, 1'b0);
    advanceTo(3330);
    checkOutput("flp_done", burst_done, 1'b1);
    advanceTo(3331);
    checkOutput("flp_a5a5_strobes", strobeCount - snap, 25);

    $display("[TB] code word changed mid-burst");
    applyStimulus(1'b1, 1'b0, 1'b1, 16'h0000);
    advanceTo(4000);
    snap = strobeCount;
    applyStimulus(1'b1, 1'b0, 1'b1, 16'hFFFF);
    advanceTo(4331);
    checkOutput("flp_0000_strobes", strobeCount - snap, 17);
    advanceTo(5000);
    snap = strobeCount;
    advanceTo(5331);
    checkOutput("flp_ffff_strobes", strobeCount - snap, 33);

    $display("[TB] tx_active abort");
    advanceTo(6050);
    checkOutput("slot5_pulse", Ethernet_TDp, 1'b1);
    snap = doneCount;
    applyStimulus(1'b1, 1'b1, 1'b1, 16'hFFFF);
    advanceTo(6051);
    checkOutput("tx_abort_tdp", Ethernet_TDp, 1'b0);
    advanceTo(6100);
    applyStimulus(1'b1, 1'b0, 1'b1, 16'hFFFF);
    advanceTo(7099);
    checkOutput("after_tx_before", Ethernet_TDp, 1'b0);
    checkOutput("abort_no_done", doneCount - snap, 0);
    advanceTo(7100);
    checkOutput("after_tx_tdp", Ethernet_TDp, 1'b1);
    checkOutput("after_tx_strobe", pulse_strobe, 1'b1);

    $display("[TB] hold coincident with burst start");
    advanceTo(8099);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'hFFFF);
    advanceTo(8100);
    checkOutput("hold_wins_tdp", Ethernet_TDp, 1'b0);
    checkOutput("hold_wins_strobe", pulse_strobe, 1'b0);
    advanceTo(8105);
    applyStimulus(1'b1, 1'b0, 1'b1, 16'hFFFF);
    advanceTo(9104);
    checkOutput("after_enable_before", Ethernet_TDp, 1'b0);
    advanceTo(9105);
    checkOutput("after_enable_tdp", Ethernet_TDp, 1'b1);

    $display("[TB] reset during pulse");
    #1 reset_n = 1'b0;
    #1;
    checkOutput("async_reset_tdp", Ethernet_TDp, 1'b0);
    checkOutput("async_reset_strobe", pulse_strobe, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
    @(negedge clk20);
    reset_n = 1'b1;
    cyc = 0;
    advanceTo(999);
    checkOutput("rerelease_before", Ethernet_TDp, 1'b0);
    advanceTo(1000);
    checkOutput("rerelease_tdp", Ethernet_TDp, 1'b1);
    checkOutput("tdp_tdm_exclusive", overlapCount, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/eth_link_pulse_gen.md
Name: eth_link_pulse_gen

Overview:
Parametrised 10BASE-T link-pulse generator; successor to the fixed NLP-only generator.
- NLP mode: one pulse per burst.
- FLP mode: 33-slot Fast Link Pulse burst carrying a 16-bit auto-negotiation link code word.
- Sits between the MAC/TX path and the differential TD pins.
- Pulses are suppressed while the transmitter is active or the block is disabled.

Parameters:
- NLP_PERIOD, 320000: cycles between burst starts (16 ms at 20 MHz).
- SLOT_PERIOD, 1250: cycles between FLP pulse-slot starts (62.5 us).
- PULSE_WIDTH, 2: cycles each pulse is held high (100 ns).
- TAIL_WIDTH, 1: cycles of negative tail per pulse. Used only with ETH_LP_TAIL_EN.

Ports:
- clk20: in, 1. 20 MHz clock, sole clock domain.
- reset_n: in, 1. Asynchronous, active-low reset.
- enable: in, 1. Pulse generation permitted.
- tx_active: in, 1. Data transmission in progress; suppresses pulses.
- mode_flp: in, 1. 1 = FLP bursts, 0 = NLP single pulses.
- link_code_word: in, 16. FLP data bits; D0 is sent first.
- Ethernet_TDp: out, 1. Positive differential output, registered.
- Ethernet_TDm: out, 1. Negative differential output, registered.
- pulse_strobe: out, 1. One-cycle high on the first cycle of every emitted pulse.
- burst_done: out, 1. One-cycle high on the cycle after the last slot of a burst completes.

Behaviour:
- Reset values:
  - All outputs 0.
  - Interval counter 0; slot index 0; FSM in WAIT.
- Hold condition: `hold = !enable | tx_active`.
  - While hold is true: TDp = TDm = 0, interval counter held at 0, FSM forced to WAIT, any in-progress burst aborted.
  - No burst_done is issued for an aborted burst.
- Interval counting:
  - The interval counter counts 0..NLP_PERIOD-1 and wraps.
  - A burst starts on the cycle the counter equals NLP_PERIOD-1.
  - The interval is measured start-to-start and keeps running during a burst.
  - Invariant: NLP_PERIOD > 33*SLOT_PERIOD.
- Burst start: mode_flp and link_code_word are latched into shadow registers. Changes mid-burst have no effect until the next burst.
- FSM states:
  - WAIT: idle; go to SLOT at burst start.
  - SLOT: PULSE_WIDTH cycles. TDp = pulse_bit, TDm = 0, pulse_strobe on the first cycle if pulse_bit = 1. Then go to GAP.
  - GAP: fills the remainder of SLOT_PERIOD (SLOT_PERIOD - PULSE_WIDTH cycles) with outputs low. Then:
    - if the slot is the last one, return to WAIT with burst_done;
    - otherwise increment the slot index and go to SLOT.
- Slot count and pulse_bit:
  - NLP mode: 1 slot; pulse_bit = 1.
  - FLP mode: 33 slots, index 0..32.
    - Even index: clock pulse, pulse_bit = 1.
    - Odd index k: pulse_bit = code[(k-1)/2].
- Latency: TDp rises one cycle after the burst-start cycle, because outputs are registered.
- First burst after reset release or hold release begins NLP_PERIOD cycles after release. Its first TDp high is at cycle NLP_PERIOD.
- Hold assertion coincident with burst start: hold wins; no pulse is emitted.
- Reset mid-pulse: outputs drop immediately (asynchronous reset).
- Counter widths: $clog2 of the corresponding parameter; slot index is 6 bits.

Optional Feature:
- Macro: ETH_LP_TAIL_EN.
- Defined: each pulse is followed immediately by TAIL_WIDTH cycles with TDp = 0, TDm = 1 (negative tail). The tail is taken from the GAP time. Invariant: SLOT_PERIOD > PULSE_WIDTH + TAIL_WIDTH.
- Undefined: TDm is constant 0, and no tail logic is synthesised.

Decomposition:
- Package eth_lp_pkg holds:
  - FSM state enum {WAIT, SLOT, GAP};
  - constants FLP_SLOTS = 33, NLP_SLOTS = 1;
  - a function mapping slot index plus code word to pulse_bit.
- One sub-module: eth_lp_interval_timer, a wrap counter with sync clear that produces the terminal-count strobe.

Test Plan:
- Simulation parameters: NLP_PERIOD = 1000, SLOT_PERIOD = 10, PULSE_WIDTH = 2.
- NLP, enable = 1 from reset -> TDp high at cycles 1000-1001, 2000-2001, ...; one pulse_strobe per period; burst_done at cycle 1010.
- FLP, code = 16'hA5A5 -> 17 clock pulses plus 8 data pulses (25 strobes) within 330 cycles. Slot 1 (D0 = 1) has a pulse; slot 3 (D1 = 0) is empty.
- FLP, code changed mid-burst from 16'h0000 to 16'hFFFF -> current burst has 17 pulses; next burst has 33.
- tx_active raised at slot 5 and dropped 50 cycles later -> TDp low immediately, no burst_done, next burst starts 1000 cycles after the drop.
- With ETH_LP_TAIL_EN, TAIL_WIDTH = 1 -> TDm high exactly on the cycle after each 2-cycle TDp pulse; TDp and TDm are never both high.
- reset_n asserted during a TDp pulse -> all outputs 0 in the same cycle; first pulse 1000 cycles after release.
